// File: rtl/fault_test_sequencer.sv
// rtl/fault_test_sequencer.sv - exhaustive good/faulty UUT sweep controller
module fault_test_sequencer #(
  parameter int NIN    = 4,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           stop_on_first,
  output logic [NIN-1:0] vec_out,
  input  logic           y_good,
  input  logic           y_fault,
  output logic           busy,
  output logic           done,
  output logic           detected,
  output logic [NIN-1:0] first_vec,
  output logic [NIN:0]   det_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0]     SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [NIN-1:0] VEC_LAST    = '1;
  localparam logic [NIN-1:0] VEC_ONE     = NIN'(1);
  localparam logic [NIN:0]   CNT_ONE     = (NIN + 1)'(1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       stop_lat;
  logic       mismatch;
  logic       sweep_end;

  // UUT outputs only matter in COMPARE; the sweep ends at all-ones or on an early stop
  assign mismatch  = y_good ^ y_fault;
  assign sweep_end = (vec_out == VEC_LAST) || (mismatch && stop_lat);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   if (settle_cnt == 4'd0) state_nxt = COMPARE;
      COMPARE: state_nxt = sweep_end ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded purely from the state flops, so no input reaches them
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      APPLY:   busy = 1'b1;
      COMPARE: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Vector stepping, settle timing and result accumulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_out    <= '0;
      settle_cnt <= 4'd0;
      stop_lat   <= 1'b0;
      detected   <= 1'b0;
      first_vec  <= '0;
      det_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec_out    <= '0;
            det_count  <= '0;
            detected   <= 1'b0;
            first_vec  <= '0;
            stop_lat   <= stop_on_first;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        APPLY: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        COMPARE: begin
          if (mismatch) begin
            det_count <= det_count + CNT_ONE;
            if (!detected) begin
              detected  <= 1'b1;
              first_vec <= vec_out;
            end
          end
          if (!sweep_end) begin
            vec_out    <= vec_out + VEC_ONE;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fault_test_sequencer.sv
// tb/tb_fault_test_sequencer.sv - scoreboard bench for fault_test_sequencer
module tb_fault_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, stop_on_first;
  logic       start1, start3;
  logic [3:0] vec1, fv1, vec3, fv3;
  logic [4:0] cnt1, cnt3;
  logic       busy1, done1, det1, busy3, done3, det3;
  logic       yg1, yf1, yg3, yf3;
  logic       mode;
  logic       act3 = 1'b0;
  logic       trace_en = 1'b0;

  int cyc = 0;
  int k1_last = 0;
  int k3_last = 0;
  int pass_cnt = 0;
  int tot_cnt = 0;

  typedef struct {
    int         done_cyc;
    logic       det;
    logic [3:0] fv;
    logic [4:0] cnt;
    logic [3:0] vec;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  logic done1_d = 1'b0;
  logic done3_d = 1'b0;

  // Faulty UUT differs from the good one only on 0101 and 1101 when mode is set
  assign yg1 = ^vec1;
  assign yf1 = yg1 ^ (mode && (vec1 == 4'b0101 || vec1 == 4'b1101));
  assign yg3 = 1'b0;

  fault_test_sequencer #(.NIN(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop_on_first(stop_on_first),
    .vec_out(vec1), .y_good(yg1), .y_fault(yf1), .busy(busy1), .done(done1),
    .detected(det1), .first_vec(fv1), .det_count(cnt1)
  );

  fault_test_sequencer #(.NIN(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stop_on_first(stop_on_first),
    .vec_out(vec3), .y_good(yg3), .y_fault(yf3), .busy(busy3), .done(done3),
    .detected(det3), .first_vec(fv3), .det_count(cnt3)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Glitch the faulty output during the first two cycles of every 4-cycle slot
  always @(negedge clk) yf3 = act3 && busy3 && (((cyc - k3_last - 1) % 4) < 2);

  task automatic check(input string name, input int act, input int req);
    tot_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic cmp_exp(input string tag, input exp_t e, input int det,
                         input int fv, input int cnt, input int vec);
    check({tag, " done_cycle"}, cyc, e.done_cyc);
    check({tag, " detected"}, det, int'(e.det));
    check({tag, " first_vec"}, fv, int'(e.fv));
    check({tag, " det_count"}, cnt, int'(e.cnt));
    check({tag, " vec_at_done"}, vec, int'(e.vec));
  endtask

  function automatic exp_t mk(input int dc, input logic d, input logic [3:0] f,
                              input logic [4:0] c, input logic [3:0] v);
    exp_t e;
    e.done_cyc = dc; e.det = d; e.fv = f; e.cnt = c; e.vec = v;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done1_d) check("dut1 busy_after_done", busy1, 0);
    done1_d = done1;
    if (done1) begin
      if (q1.size() == 0) check("dut1 unexpected_done", 1, 0);
      else begin
        e1 = q1.pop_front();
        cmp_exp("dut1", e1, det1, fv1, cnt1, vec1);
      end
    end
    if (trace_en && busy1 && !done1) check("dut1 vec_trace", vec1, (cyc - k1_last - 1) / 2);
  end

  always @(negedge clk) begin
    if (done3_d) check("dut3 busy_after_done", busy3, 0);
    done3_d = done3;
    if (done3) begin
      if (q3.size() == 0) check("dut3 unexpected_done", 1, 0);
      else begin
        e3 = q3.pop_front();
        cmp_exp("dut3", e3, det3, fv3, cnt3, vec3);
      end
    end
  end

  task automatic go1(input logic stop, output int k);
    @(negedge clk);
    start1 = 1'b1;
    stop_on_first = stop;
    k = cyc;
    k1_last = cyc;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic go3(input logic stop, output int k);
    @(negedge clk);
    start3 = 1'b1;
    stop_on_first = stop;
    k = cyc;
    k3_last = cyc;
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic wait_all(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q3.size() == 0 && !busy1 && !busy3) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("sweep_timeout", 0, 1);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; stop_on_first = 1'b0; mode = 1'b0;
    repeat (2) @(negedge clk);
    check("reset vec_out", vec1, 0);
    check("reset busy", busy1, 0);
    check("reset done", done1, 0);
    check("reset detected", det1, 0);
    check("reset first_vec", fv1, 0);
    check("reset det_count", cnt1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identical UUTs, full sweep with vec_out trace
    mode = 1'b0; trace_en = 1'b1;
    go1(1'b0, k);
    q1.push_back(mk(k + 33, 1'b0, 4'd0, 5'd0, 4'd15));
    wait_all(200);
    trace_en = 1'b0;

    // Two faulty vectors, full sweep
    mode = 1'b1;
    go1(1'b0, k);
    q1.push_back(mk(k + 33, 1'b1, 4'd5, 5'd2, 4'd15));
    wait_all(200);

    // Two faulty vectors, stop on first
    go1(1'b1, k);
    q1.push_back(mk(k + 13, 1'b1, 4'd5, 5'd1, 4'd5));
    wait_all(200);

    // SETTLE=3 with glitches confined to APPLY
    act3 = 1'b1;
    go3(1'b0, k);
    q3.push_back(mk(k + 65, 1'b0, 4'd0, 5'd0, 4'd15));
    wait_all(300);
    act3 = 1'b0;

    // Reset mid-sweep at vector 7, then a clean full sweep
    mode = 1'b1;
    go1(1'b0, k);
    for (int i = 0; i < 100; i++) begin
      if (vec1 == 4'd7) break;
      @(negedge clk);
    end
    check("midreset vec_reached", vec1, 7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset busy", busy1, 0);
    check("midreset done", done1, 0);
    check("midreset det_count", cnt1, 0);
    check("midreset detected", det1, 0);
    check("midreset vec_out", vec1, 0);
    repeat (3) @(negedge clk);
    go1(1'b0, k);
    q1.push_back(mk(k + 33, 1'b1, 4'd5, 5'd2, 4'd15));
    wait_all(200);

    // Start pulses while busy are ignored
    mode = 1'b0;
    go1(1'b0, k);
    q1.push_back(mk(k + 33, 1'b0, 4'd0, 5'd0, 4'd15));
    while (cyc < k + 5) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (cyc < k + 20) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_all(200);

    // Start held high: second sweep accepted right after DONE->IDLE
    mode = 1'b1;
    @(negedge clk);
    start1 = 1'b1;
    stop_on_first = 1'b0;
    k = cyc;
    k1_last = cyc;
    q1.push_back(mk(k + 33, 1'b1, 4'd5, 5'd2, 4'd15));
    q1.push_back(mk(k + 67, 1'b1, 4'd5, 5'd2, 4'd15));
    while (cyc < k + 36) @(negedge clk);
    start1 = 1'b0;
    wait_all(300);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/fault_test_sequencer.md
# fault_test_sequencer

Sequential controller that drives exhaustive test vectors into a good/faulty unit-under-test pair and compares their outputs. It applies every NIN-bit input vector in ascending order and waits a programmable settle time before sampling both outputs. It records whether the fault was detected, the first detecting vector, and the number of detecting vectors. It sits between a test-control host, which issues start and reads results, and the combinational UUT pair.

## Interface
Parameters:
- NIN, default 4: UUT input width; the sweep covers vectors 0 .. 2^NIN-1.
- SETTLE, default 1: number of cycles a vector is held before compare; legal range 1..15.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous reset, active-low, sampled on the clk rising edge.
- start, input, 1: begin a sweep; sampled only in IDLE.
- stop_on_first, input, 1: end the sweep at the first mismatch; sampled with start and latched for the run.
- vec_out, output, NIN: test vector driven to both UUTs ({A,B,C,D} order for NIN=4, MSB = A).
- y_good, input, 1: fault-free UUT output.
- y_fault, input, 1: faulty UUT output.
- busy, output, 1: high from the cycle after start is accepted until DONE is left.
- done, output, 1: one-cycle pulse when the sweep ends.
- detected, output, 1: at least one mismatch occurred in the last run.
- first_vec, output, NIN: vector of the first mismatch; 0 if none.
- det_count, output, NIN+1: number of mismatching vectors; range 0..2^NIN.

## Operation
- State machine states: IDLE, APPLY, COMPARE, DONE. Reset state is IDLE.
- IDLE
  - start=1: clear vec_out, det_count, detected and first_vec to 0; latch stop_on_first; load the settle counter with SETTLE-1; next state is APPLY.
  - start=0: stay in IDLE; result outputs hold their values.
- APPLY: vec_out is held.
  - Settle counter nonzero: decrement it.
  - Settle counter zero: next state is COMPARE.
- COMPARE: vec_out is still held; compute mismatch = y_good XOR y_fault.
  - Mismatch: det_count increments.
  - Mismatch while detected=0: set detected=1 and first_vec=vec_out.
  - vec_out = 2^NIN-1, or (mismatch and the latched stop_on_first=1): next state is DONE.
  - Otherwise: vec_out increments, the settle counter reloads to SETTLE-1, next state is APPLY.
- DONE: done=1 for exactly one cycle; next state is IDLE. vec_out holds the last applied vector.
- Arithmetic and widths:
  - vec_out never wraps; the sweep terminates at all-ones.
  - det_count is NIN+1 bits, so it cannot overflow.
- Boundary conditions:
  - start while busy, or while in DONE, is ignored.
  - start asserted on the same cycle as the DONE→IDLE transition is not seen; the next cycle's start is accepted.
  - y_good and y_fault are only sampled in COMPARE; glitches in APPLY are ignored.
  - rst_n low in any state, including mid-sweep: the next edge forces IDLE and clears every output. No done pulse is produced; partial results are discarded.
- Reset values: vec_out=0, busy=0, done=0, detected=0, first_vec=0, det_count=0.

## Timing
- start is accepted at edge k.
  - busy=1 and vec_out=0 from cycle k+1.
  - Vector i is held on cycles k+1+i(SETTLE+1) through k+(i+1)(SETTLE+1).
  - The COMPARE cycle is the last cycle of each vector's slot.
- Full sweep: done is high in cycle k+1+2^NIN·(SETTLE+1). With NIN=4 and SETTLE=1 that is k+33. busy falls the cycle after done.
- Early stop at vector j: done is high in cycle k+1+(j+1)(SETTLE+1).
- Result outputs update at the COMPARE edge and are stable when done=1.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Identical UUTs (y_fault = y_good = any function of vec_out), start pulse, SETTLE=1 → done in cycle k+33; detected=0, det_count=0, first_vec=0; vec_out stepped 0..15, each held 2 cycles.
- Fault model where y_fault ≠ y_good only for vectors 4'b0101 and 4'b1101, stop_on_first=0 → detected=1, first_vec=4'b0101, det_count=2, done at k+33.
- Same fault model, stop_on_first=1 → done at k+13 (j=5), det_count=1, first_vec=4'b0101, vec_out=4'b0101 at done.
- SETTLE=3, with a mismatch pulse on y_fault only during the first 2 cycles of each APPLY slot → det_count=0; vector slots are 4 cycles; done at k+65.
- rst_n driven low for one cycle while vec_out=7, mid-sweep → next cycle: IDLE, busy=0, det_count=0, no done pulse. A following start produces a complete, correct sweep.
- Boundary start handling:
  - start pulses at cycles k+5 and k+20 during a sweep → ignored, and the sweep timing is unchanged.
  - start held high continuously → a new sweep begins 2 cycles after the done pulse (DONE→IDLE, then accept).
